// File: rtl/fc_pkg.sv
// Shared definitions for the FC core feeder: FSM states and default widths.
// Imported by the feeder RTL, its bus interface and the bench.
package fc_pkg;

    localparam int IN_DATA_WIDTH_DEF = 9;
    localparam int ADDR_WIDTH_DEF    = 8;
    localparam int RESULT_MULT       = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } fc_state_e;

    // The accumulator carries four times the operand width, so products and
    // long sums have headroom before wrapping.
    function automatic int result_width(input int data_width);
        return RESULT_MULT * data_width;
    endfunction

endpackage

// File: rtl/fc_core_feeder_if.sv
// Bus bundle between the feeder and its node/weight buffers, FC core and controller.
// The master modport is the feeder's view; slave is the surrounding environment.
interface fc_core_feeder_if
    import fc_pkg::*;
#(
    parameter int IN_DATA_WIDTH = IN_DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF
);
    localparam int RES_WIDTH = result_width(IN_DATA_WIDTH);

    logic                           i_start;
    logic [ADDR_WIDTH-1:0]          i_num_node;
    logic signed [IN_DATA_WIDTH-1:0] i_bias;

    logic                           o_node_ce;
    logic [ADDR_WIDTH-1:0]          o_node_addr;
    logic signed [IN_DATA_WIDTH-1:0] i_node_q;

    logic                           o_wegt_ce;
    logic [ADDR_WIDTH-1:0]          o_wegt_addr;
    logic signed [IN_DATA_WIDTH-1:0] i_wegt_q;

    logic                           o_core_run;
    logic                           o_core_valid;
    logic signed [IN_DATA_WIDTH-1:0] o_core_node;
    logic signed [IN_DATA_WIDTH-1:0] o_core_wegt;
    logic signed [IN_DATA_WIDTH-1:0] o_core_bias;
    logic                           i_core_valid;
    logic signed [RES_WIDTH-1:0]    i_core_result;

    logic                           o_idle;
    logic                           o_running;
    logic                           o_done;
    logic signed [RES_WIDTH-1:0]    o_result;

    modport master (
        input  i_start, i_num_node, i_bias,
        output o_node_ce, o_node_addr,
        input  i_node_q,
        output o_wegt_ce, o_wegt_addr,
        input  i_wegt_q,
        output o_core_run, o_core_valid, o_core_node, o_core_wegt, o_core_bias,
        input  i_core_valid, i_core_result,
        output o_idle, o_running, o_done, o_result
    );

    modport slave (
        output i_start, i_num_node, i_bias,
        input  o_node_ce, o_node_addr,
        output i_node_q,
        input  o_wegt_ce, o_wegt_addr,
        output i_wegt_q,
        input  o_core_run, o_core_valid, o_core_node, o_core_wegt, o_core_bias,
        output i_core_valid, i_core_result,
        input  o_idle, o_running, o_done, o_result
    );

endinterface

// File: rtl/fc_core_feeder.sv
// Streams N node/weight pairs from two buffers into an FC accumulation core,
// injects the bias once, and captures the core result after the N-th accumulate.
module fc_core_feeder
    import fc_pkg::*;
#(
    parameter int IN_DATA_WIDTH = IN_DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF
)(
    input  logic             clk,
    input  logic             reset,
    fc_core_feeder_if.master bus
);

    localparam int RES_WIDTH = result_width(IN_DATA_WIDTH);

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    fc_state_e                       state_q, state_d;
    addr_t                           num_q, num_d;
    addr_t                           addr_q, addr_d;
    addr_t                           beat_q, beat_d;
    logic signed [IN_DATA_WIDTH-1:0] bias_q, bias_d;
    logic                            valid_q, valid_d;
    logic                            first_q, first_d;
    logic signed [RES_WIDTH-1:0]     result_q, result_d;

    logic read_ce;
    logic last_addr;
    logic beat_en;
    logic last_beat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            num_q    <= '0;
            addr_q   <= '0;
            beat_q   <= '0;
            bias_q   <= '0;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            addr_q   <= addr_d;
            beat_q   <= beat_d;
            bias_q   <= bias_d;
            valid_q  <= valid_d;
            first_q  <= first_d;
            result_q <= result_d;
        end
    end

    // Accumulate beats from the core only while a run is in flight; stray
    // valids in IDLE/CLEAR/DONE must not disturb the counter or the result.
    always_comb begin
        read_ce   = (state_q == READ);
        last_addr = (addr_q == (num_q - addr_t'(1)));
        beat_en   = bus.i_core_valid && ((state_q == READ) || (state_q == DRAIN));
        last_beat = beat_en && (beat_q == (num_q - addr_t'(1)));
    end

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        addr_d   = addr_q;
        beat_d   = beat_q;
        bias_d   = bias_q;
        valid_d  = read_ce;
        first_d  = first_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d  = CLEAR;
                    num_d    = bus.i_num_node;
                    bias_d   = bus.i_bias;
                    result_d = '0;
                    addr_d   = '0;
                    beat_d   = '0;
                end
            end
            CLEAR: begin
                first_d = 1'b1;
                state_d = (num_q != '0) ? READ : DONE;
            end
            READ: begin
                addr_d = addr_q + addr_t'(1);
                if (last_addr) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DRAIN;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The bias rides only on the first operand beat of each run.
        if (valid_q) begin
            first_d = 1'b0;
        end

        if (beat_en) begin
            beat_d = beat_q + addr_t'(1);
            if (last_beat) begin
                result_d = bus.i_core_result;
                state_d  = DONE;
            end
        end
    end

    always_comb begin
        bus.o_node_ce    = read_ce;
        bus.o_wegt_ce    = read_ce;
        bus.o_node_addr  = read_ce ? addr_q : '0;
        bus.o_wegt_addr  = read_ce ? addr_q : '0;
        bus.o_core_run   = (state_q == CLEAR);
        bus.o_core_valid = valid_q;
        bus.o_core_node  = valid_q ? bus.i_node_q : '0;
        bus.o_core_wegt  = valid_q ? bus.i_wegt_q : '0;
        bus.o_core_bias  = (valid_q && first_q) ? bias_q : '0;
        bus.o_idle       = (state_q == IDLE);
        bus.o_running    = (state_q == CLEAR) || (state_q == READ) || (state_q == DRAIN);
        bus.o_done       = (state_q == DONE);
        bus.o_result     = result_q;
    end

endmodule

// File: tb/tb_fc_core_feeder.sv
// Bench for fc_core_feeder: buffer and 1-cycle core models drive the DUT, a
// reference sum predicts each result, and a negedge monitor scores every run.
module tb_fc_core_feeder;
    import fc_pkg::*;

    localparam int DW = IN_DATA_WIDTH_DEF;
    localparam int AW = ADDR_WIDTH_DEF;
    localparam int RW = result_width(DW);

    typedef struct {
        int             n;
        int             bias;
        logic [RW-1:0]  result;
        int             start_cyc;
    } op_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    int   node_val [256];
    int   wegt_val [256];
    op_t  exp_q [$];

    logic          inject_valid = 1'b0;
    logic [RW-1:0] inject_result = '0;
    logic [RW-1:0] last_result = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    fc_core_feeder_if #(.IN_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fc_core_feeder #(.IN_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [63:0] msk(input logic [63:0] v, input int w);
        return v & ((64'd1 << w) - 64'd1);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic req);
        checkOutput(name, 64'(act), 64'(req));
    endtask

    task automatic failEvent(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s actual=missing required=present at cycle %0d", name, cyc);
    endtask

    // Synchronous buffers plus a 1-cycle accumulating core, sampled on the edge.
    logic                  m_ce_n, m_ce_w, m_cv, m_run;
    logic [AW-1:0]         m_a_n, m_a_w;
    logic signed [DW-1:0]  m_cn, m_cw, m_cb;
    logic signed [RW-1:0]  acc;

    initial begin
        bus.i_node_q      = '0;
        bus.i_wegt_q      = '0;
        bus.i_core_valid  = 1'b0;
        bus.i_core_result = '0;
        acc               = '0;
        forever begin
            @(posedge clk);
            m_ce_n = bus.o_node_ce;
            m_ce_w = bus.o_wegt_ce;
            m_a_n  = bus.o_node_addr;
            m_a_w  = bus.o_wegt_addr;
            m_cv   = bus.o_core_valid;
            m_run  = bus.o_core_run;
            m_cn   = bus.o_core_node;
            m_cw   = bus.o_core_wegt;
            m_cb   = bus.o_core_bias;
            #1;
            bus.i_node_q = m_ce_n ? DW'(node_val[m_a_n]) : DW'($urandom);
            bus.i_wegt_q = m_ce_w ? DW'(wegt_val[m_a_w]) : DW'($urandom);
            if (m_run) acc = '0;
            if (m_cv) acc = acc + m_cn * m_cw + m_cb;
            bus.i_core_valid  = m_cv | inject_valid;
            bus.i_core_result = inject_valid ? inject_result : acc;
        end
    end

    // Monitor: tracks one run at a time against the head of the scoreboard.
    int   mon_addr = 0;
    int   mon_beat = 0;
    int   mon_runs = 0;
    logic mon_done_prev = 1'b0;
    op_t  mon_op;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_addr = 0;
                mon_beat = 0;
                mon_runs = 0;
                mon_done_prev = 1'b0;
            end else begin
                if (mon_done_prev) checkBit("done_pulse_width", bus.o_done, 1'b0);
                mon_done_prev = bus.o_done;
                if (bus.o_core_run) begin
                    if (exp_q.size() == 0) failEvent("run_without_start");
                    else checkOutput("run_cycle", 64'(cyc), 64'(exp_q[0].start_cyc));
                    mon_addr = 0;
                    mon_beat = 0;
                    mon_runs++;
                end
                if (bus.o_node_ce || bus.o_wegt_ce) begin
                    checkBit("node_ce", bus.o_node_ce, 1'b1);
                    checkBit("wegt_ce", bus.o_wegt_ce, 1'b1);
                    checkOutput("node_addr", 64'(bus.o_node_addr), 64'(mon_addr));
                    checkOutput("wegt_addr", 64'(bus.o_wegt_addr), 64'(mon_addr));
                    checkBit("running_in_read", bus.o_running, 1'b1);
                    mon_addr++;
                end
                if (bus.o_core_valid) begin
                    if (exp_q.size() > 0 && mon_beat < 256) begin
                        checkOutput("core_node", msk(64'(bus.o_core_node), DW), msk(64'(node_val[mon_beat]), DW));
                        checkOutput("core_wegt", msk(64'(bus.o_core_wegt), DW), msk(64'(wegt_val[mon_beat]), DW));
                        checkOutput("core_bias", msk(64'(bus.o_core_bias), DW),
                                    msk(64'((mon_beat == 0) ? exp_q[0].bias : 0), DW));
                    end
                    mon_beat++;
                end else begin
                    checkOutput("quiet_operands",
                                msk(64'(bus.o_core_node), DW) | msk(64'(bus.o_core_wegt), DW) | msk(64'(bus.o_core_bias), DW),
                                64'd0);
                end
                if (bus.o_done) begin
                    if (exp_q.size() == 0) begin
                        failEvent("done_without_start");
                    end else begin
                        mon_op = exp_q.pop_front();
                        checkOutput("result", msk(64'(bus.o_result), RW), msk(64'(mon_op.result), RW));
                        checkOutput("ce_beats", 64'(mon_addr), 64'(mon_op.n));
                        checkOutput("valid_beats", 64'(mon_beat), 64'(mon_op.n));
                        checkOutput("run_pulses", 64'(mon_runs), 64'd1);
                        checkOutput("done_cycle", 64'(cyc),
                                    64'(mon_op.start_cyc + ((mon_op.n == 0) ? 1 : mon_op.n + 3)));
                    end
                    mon_runs = 0;
                end
            end
        end
    end

    task automatic loadRandom(input int n);
        for (int i = 0; i < n; i++) begin
            node_val[i] = int'($urandom_range(511)) - 256;
            wegt_val[i] = int'($urandom_range(511)) - 256;
        end
    endtask

    // Reference: a run of N>0 yields bias + sum(node*weight) wrapped to RW bits;
    // a run of N=0 never sees a core beat and leaves the cleared result at 0.
    task automatic applyStimulus(input int n, input int b);
        op_t    op;
        longint s;
        int     guard;
        guard = 0;
        while (!bus.o_idle && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.o_idle) failEvent("idle_before_start");
        s = longint'(b);
        for (int i = 0; i < n; i++) s += longint'(node_val[i]) * longint'(wegt_val[i]);
        op.n         = n;
        op.bias      = b;
        op.result    = (n == 0) ? '0 : RW'(s);
        op.start_cyc = cyc + 1;
        exp_q.push_back(op);
        last_result  = op.result;
        bus.i_start    = 1'b1;
        bus.i_num_node = AW'(n);
        bus.i_bias     = DW'(b);
        @(negedge clk);
        bus.i_start    = 1'b0;
        bus.i_num_node = AW'($urandom);
        bus.i_bias     = DW'($urandom);
    endtask

    task automatic waitDone();
        int k;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (bus.o_done) break;
        end
        if (k == 2000) failEvent("done_timeout");
    endtask

    task automatic checkQuiet(input string tag);
        checkBit({tag, "_idle"}, bus.o_idle, 1'b1);
        checkBit({tag, "_running"}, bus.o_running, 1'b0);
        checkBit({tag, "_done"}, bus.o_done, 1'b0);
        checkBit({tag, "_run"}, bus.o_core_run, 1'b0);
        checkBit({tag, "_ce"}, bus.o_node_ce | bus.o_wegt_ce, 1'b0);
        checkBit({tag, "_valid"}, bus.o_core_valid, 1'b0);
        checkOutput({tag, "_result"}, msk(64'(bus.o_result), RW), 64'd0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.i_start    = 1'b0;
        bus.i_num_node = '0;
        bus.i_bias     = '0;
        for (int i = 0; i < 256; i++) begin
            node_val[i] = 0;
            wegt_val[i] = 0;
        end
        repeat (3) @(negedge clk);
        checkQuiet("reset");
        reset = 1'b0;
        @(negedge clk);
        checkBit("idle_after_reset", bus.o_idle, 1'b1);

        for (int i = 0; i < 4; i++) begin
            node_val[i] = i + 1;
            wegt_val[i] = 1;
        end
        applyStimulus(4, 5);
        waitDone();

        node_val[0] = -3;
        wegt_val[0] = 2;
        applyStimulus(1, -1);
        waitDone();

        applyStimulus(0, 7);
        waitDone();

        // A core valid while idle must leave the held result alone.
        loadRandom(6);
        applyStimulus(6, int'($urandom_range(511)) - 256);
        waitDone();
        @(negedge clk);
        inject_result = RW'($urandom);
        inject_valid  = 1'b1;
        @(negedge clk);
        inject_valid  = 1'b0;
        @(negedge clk);
        checkOutput("result_held_idle", msk(64'(bus.o_result), RW), msk(64'(last_result), RW));
        checkBit("idle_after_stray_valid", bus.o_idle, 1'b1);

        loadRandom(4);
        applyStimulus(4, 33);
        @(negedge clk);
        bus.i_start    = 1'b1;
        bus.i_num_node = AW'(9);
        bus.i_bias     = DW'(-100);
        @(negedge clk);
        bus.i_start    = 1'b0;
        waitDone();

        loadRandom(8);
        applyStimulus(8, 12);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checkQuiet("midrun_reset");
        reset = 1'b0;
        @(negedge clk);
        checkQuiet("after_midrun_reset");
        loadRandom(2);
        applyStimulus(2, -20);
        waitDone();

        for (int i = 0; i < 255; i++) begin
            node_val[i] = -1;
            wegt_val[i] = -1;
        end
        applyStimulus(255, -1);
        waitDone();
        loadRandom(17);
        applyStimulus(17, 100);
        waitDone();

        for (int t = 0; t < 12; t++) begin
            int n;
            n = int'($urandom_range(24));
            loadRandom(n);
            applyStimulus(n, int'($urandom_range(511)) - 256);
            waitDone();
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
